spi_xfer_sequencer: RTL and testbench
=====================================

Name: spi_xfer_sequencer

Overview:
Upstream/downstream companion to the SPI master core. It buffers host bytes in a TX FIFO and launches one SPI transfer per byte, keeping the core's select asserted across a burst. It captures each returned RX_DATA word into an RX FIFO for the host. It sits between the host register interface and the SPI core's ENABLE/ADDR/TX_DATA/BUSY/RX_DATA pins.

Parameters:
D_PACK, 8, data word width; must match the SPI core's D_Pack
FIFO_AW, 2, FIFO address width; each FIFO holds 2**FIFO_AW words
BUSY_TMO, 15, maximum cycles to wait for SPI_BUSY to rise after launch

Ports:
CLOCK  in  1  system clock; all logic on the rising edge
RST  in  1  asynchronous, active-low reset
WR_EN  in  1  host push into the TX FIFO; ignored when TX_FULL
WR_DATA  in  D_PACK  host TX word
TX_FULL  out  1  TX FIFO full
RD_EN  in  1  host pop from the RX FIFO; ignored when RX_EMPTY
RD_DATA  out  D_PACK  RX FIFO head word; valid whenever RX_EMPTY=0
RX_EMPTY  out  1  RX FIFO empty
SPI_ENABLE  out  1  SPI core enable; low = run, high = idle
SPI_ADDR  out  1  select level to the core; 0 = slave selected
SPI_TX_DATA  out  D_PACK  word presented to the core
SPI_BUSY  in  1  SPI core busy
SPI_RX_DATA  in  D_PACK  core received word
ERR  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (RST=0, asynchronous): both FIFOs empty, pointers 0; TX_FULL=0, RX_EMPTY=1, RD_DATA=0; SPI_ENABLE=1, SPI_ADDR=1, SPI_TX_DATA=0, ERR=0; FSM in IDLE.
- Reset mid-transfer: abort immediately; buffered data is discarded.
- FIFOs: the TX FIFO and the RX FIFO are independent instances of the same sub-module, each with pointers of FIFO_AW+1 bits.
  - Full = MSBs differ and the low bits are equal. Empty = pointers are equal.
  - Pointers wrap naturally.
  - Push and pop in the same cycle when neither flag blocks: occupancy is unchanged.
  - Push when full, or pop when empty: no effect, no error.
- FSM states:
  - IDLE: if the TX FIFO is non-empty and the RX FIFO is not full, pop a TX word into SPI_TX_DATA and go to LAUNCH. Otherwise SPI_ENABLE=1 and SPI_ADDR=1.
  - LAUNCH (1 cycle): drive SPI_ENABLE=0 and SPI_ADDR=0. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY:
    - Hold SPI_ENABLE=0.
    - If SPI_BUSY=1, go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches BUSY_TMO, set ERR=1 and go to IDLE, releasing SPI_ENABLE and SPI_ADDR; no RX word is written.
  - WAIT_DONE: hold the outputs. When SPI_BUSY falls to 0, go to CAPTURE.
  - CAPTURE (1 cycle): push SPI_RX_DATA into the RX FIFO. Then:
    - If the TX FIFO is non-empty and the RX FIFO will still have room after this push, pop the next TX word and go to LAUNCH with SPI_ADDR held at 0 (burst; select never deasserts).
    - Otherwise go to IDLE.
- Latency, first word into an empty, idle block:
  - WR_EN at cycle 0.
  - Word in SPI_TX_DATA and FSM in LAUNCH at cycle 2.
  - SPI_ENABLE=0 visible from cycle 2.
- Capture latency: RX_EMPTY falls 2 cycles after SPI_BUSY falls.
- Backpressure: no transfer is launched while the RX FIFO is full. TX words wait, and the bus is idle with SPI_ADDR=1.
- Host writes during a transfer are accepted if TX_FULL=0 and extend the burst when they arrive before CAPTURE.
- ERR does not stop operation; subsequent words are still attempted.
- Outputs are registered; SPI_* outputs are glitch-free.

Decomposition:
- Shared package holds:
  - FSM state encodings: IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3, CAPTURE=4; 3-bit state.
  - Default D_PACK and FIFO_AW constants.
- One sub-module, sync_fifo: parameterised by width and address width, with CLOCK/RST, push, pop, din, dout, full and empty. Instantiated twice.

Test Plan:
- Reset, then push 8'hA5; SPI model asserts BUSY for 10 cycles and returns 8'h3C -> SPI_TX_DATA=8'hA5, SPI_ENABLE=0 at cycle 2, RD_DATA=8'h3C, RX_EMPTY=0.
- Push 8'h01, 8'h02, 8'h03 back-to-back -> three transfers with SPI_ADDR held 0 throughout; RX FIFO returns the model responses in order; SPI_ADDR=1 after the third CAPTURE.
- Push 5 words with FIFO_AW=2, no reads -> TX_FULL=1 after the 4th push net of pops; after 4 transfers the RX FIFO is full and the 5th transfer is not launched until one RD_EN; then it completes.
- SPI model never raises BUSY -> ERR=1 exactly BUSY_TMO cycles after LAUNCH; SPI_ENABLE=1; RX_EMPTY remains 1; the next word is still attempted.
- Drop RST to 0 during WAIT_DONE -> SPI_ENABLE=1, SPI_ADDR=1, TX_FULL=0, RX_EMPTY=1 without a clock edge.
- Simultaneous WR_EN with FIFO pop in IDLE, and RD_EN with CAPTURE push -> occupancy counts stay correct; no word is lost or duplicated across 100 random bytes (scoreboard).

Source files
------------

// File: rtl/spi_xfer_sequencer_pkg.sv
// spi_xfer_sequencer_pkg
//   Shared constants for the SPI transfer sequencer: FSM state encodings
//   and default sizing parameters.
package spi_xfer_sequencer_pkg;

  // FSM state encodings (3-bit).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_CAPTURE   = 3'd4;

  // Default sizing.
  localparam int D_PACK_DEF   = 8;   // data word width, matches the SPI core
  localparam int FIFO_AW_DEF  = 2;   // FIFO depth = 2**FIFO_AW
  localparam int BUSY_TMO_DEF = 15;  // cycles allowed for SPI_BUSY to rise

endpackage

// File: rtl/spi_xfer_sequencer_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with FIFO_AW+1 bit wrapping pointers. The head word
//   is presented combinationally from the storage registers, so it is valid
//   whenever empty=0 and reads as zero after reset.
// Ports:
//   CLOCK        rising-edge clock
//   RST          asynchronous active-low reset
//   push / din   write din when not full
//   pop          drop the head word when not empty
//   dout         head word
//   full, empty  status flags
//   level        current occupancy (0 .. 2**AW)
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          CLOCK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Full when the pointers sit one lap apart: MSBs differ, index bits equal.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A blocked push or pop is silently dropped.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
//   Buffers host words in a TX FIFO, launches one SPI core transfer per word
//   (select held low across back-to-back words) and stores each returned
//   word in an RX FIFO for the host.
// Ports:
//   CLOCK, RST              clock, asynchronous active-low reset
//   WR_EN, WR_DATA, TX_FULL host side of the TX FIFO
//   RD_EN, RD_DATA, RX_EMPTY host side of the RX FIFO
//   SPI_ENABLE, SPI_ADDR,   registered controls to the SPI core
//   SPI_TX_DATA
//   SPI_BUSY, SPI_RX_DATA   status and returned word from the SPI core
//   ERR                     sticky BUSY-rise timeout flag
module spi_xfer_sequencer
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int D_PACK   = D_PACK_DEF,
  parameter int FIFO_AW  = FIFO_AW_DEF,
  parameter int BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [D_PACK-1:0] WR_DATA,
  output logic              TX_FULL,
  input  logic              RD_EN,
  output logic [D_PACK-1:0] RD_DATA,
  output logic              RX_EMPTY,
  output logic              SPI_ENABLE,
  output logic              SPI_ADDR,
  output logic [D_PACK-1:0] SPI_TX_DATA,
  input  logic              SPI_BUSY,
  input  logic [D_PACK-1:0] SPI_RX_DATA,
  output logic              ERR
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BUSY_TMO + 1);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              spi_enable_q, spi_enable_d;
  logic              spi_addr_q, spi_addr_d;
  logic [D_PACK-1:0] spi_tx_data_q, spi_tx_data_d;
  logic              err_q, err_d;

  logic              tx_pop, tx_empty;
  logic [D_PACK-1:0] tx_dout;
  logic [FIFO_AW:0]  tx_level_unused;
  logic              rx_push, rx_full;
  logic [FIFO_AW:0]  rx_level;
  logic              rx_room_after_push;

  sync_fifo #(.W(D_PACK), .AW(FIFO_AW)) u_tx_fifo (
    .CLOCK (CLOCK),
    .RST   (RST),
    .push  (WR_EN),
    .pop   (tx_pop),
    .din   (WR_DATA),
    .dout  (tx_dout),
    .full  (TX_FULL),
    .empty (tx_empty),
    .level (tx_level_unused)
  );

  sync_fifo #(.W(D_PACK), .AW(FIFO_AW)) u_rx_fifo (
    .CLOCK (CLOCK),
    .RST   (RST),
    .push  (rx_push),
    .pop   (RD_EN),
    .din   (SPI_RX_DATA),
    .dout  (RD_DATA),
    .full  (rx_full),
    .empty (RX_EMPTY),
    .level (rx_level)
  );

  // Burst decision in CAPTURE looks one word ahead: the word being captured
  // must leave at least one free slot for the next transfer's reply.
  assign rx_room_after_push = (int'(rx_level) + 1) < DEPTH;
  assign cnt_inc            = cnt_q + CW'(1);

  // Outputs are computed together with the next state so that the SPI
  // controls come straight from flops and change on the entering edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    spi_enable_d  = spi_enable_q;
    spi_addr_d    = spi_addr_q;
    spi_tx_data_d = spi_tx_data_q;
    err_d         = err_q;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty && !rx_full) begin
          tx_pop        = 1'b1;
          spi_tx_data_d = tx_dout;
          spi_enable_d  = 1'b0;
          spi_addr_d    = 1'b0;
          state_d       = ST_LAUNCH;
        end else begin
          spi_enable_d = 1'b1;
          spi_addr_d   = 1'b1;
        end
      end
      ST_LAUNCH: begin
        cnt_d        = '0;
        spi_enable_d = 1'b0;
        spi_addr_d   = 1'b0;
        state_d      = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (SPI_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_inc == CW'(BUSY_TMO)) begin
          // Core never answered: flag it, drop the word, release the bus.
          err_d        = 1'b1;
          spi_enable_d = 1'b1;
          spi_addr_d   = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!SPI_BUSY) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rx_push = 1'b1;
        if (!tx_empty && rx_room_after_push) begin
          tx_pop        = 1'b1;
          spi_tx_data_d = tx_dout;
          spi_enable_d  = 1'b0;
          spi_addr_d    = 1'b0;
          state_d       = ST_LAUNCH;
        end else begin
          spi_enable_d = 1'b1;
          spi_addr_d   = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        spi_enable_d = 1'b1;
        spi_addr_d   = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      spi_enable_q  <= 1'b1;
      spi_addr_q    <= 1'b1;
      spi_tx_data_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      spi_enable_q  <= spi_enable_d;
      spi_addr_q    <= spi_addr_d;
      spi_tx_data_q <= spi_tx_data_d;
      err_q         <= err_d;
    end
  end

  assign SPI_ENABLE  = spi_enable_q;
  assign SPI_ADDR    = spi_addr_q;
  assign SPI_TX_DATA = spi_tx_data_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer
//   Directed bench with a scoreboard. Host writes push the expected SPI
//   word and the expected reply (word ^ 8'h99, produced by the SPI model)
//   into queues; the SPI model and the RX monitor pop and compare.
module tb_spi_xfer_sequencer;

  localparam int BUSY_TMO = 15;
  localparam logic [7:0] RSP_XOR = 8'h99;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_full;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       spi_enable, spi_addr;
  logic [7:0] spi_tx_data;
  logic       spi_busy = 1'b0;
  logic [7:0] spi_rx_data = 8'h00;
  logic       err;

  spi_xfer_sequencer #(.D_PACK(8), .FIFO_AW(2), .BUSY_TMO(BUSY_TMO)) dut (
    .CLOCK       (clk),
    .RST         (rst),
    .WR_EN       (wr_en),
    .WR_DATA     (wr_data),
    .TX_FULL     (tx_full),
    .RD_EN       (rd_en),
    .RD_DATA     (rd_data),
    .RX_EMPTY    (rx_empty),
    .SPI_ENABLE  (spi_enable),
    .SPI_ADDR    (spi_addr),
    .SPI_TX_DATA (spi_tx_data),
    .SPI_BUSY    (spi_busy),
    .SPI_RX_DATA (spi_rx_data),
    .ERR         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_count  = 0;
  int miss_count = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  // SPI model controls and observations
  bit no_busy   = 1'b0;
  bit rand_busy = 1'b0;
  int busy_len  = 10;
  int bf_count  = 0;   // number of BUSY falling events
  int bf_cyc    = 0;   // cycle of the last BUSY fall

  // Host reader: 0 = off, 1 = read whenever data, 2 = random reads
  int rd_mode = 0;
  bit rd_one  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    vec_count++;
    miss_count++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_rsp);
    int n = 0;
    while (tx_full && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) expire("wr_tx_full");
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_rsp) begin
      tx_exp.push_back(d);
      rx_exp.push_back(d ^ RSP_XOR);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_bf(input int target, input int limit, input string name);
    int n = 0;
    while (bf_count < target && n < limit) begin
      tick(); n++;
    end
    if (n >= limit) expire(name);
  endtask

  task automatic wait_drain(input int limit, input string name);
    int n = 0;
    while ((rx_exp.size() != 0 || !rx_empty) && n < limit) begin
      tick(); n++;
    end
    if (n >= limit) expire(name);
  endtask

  // SPI core model: answers each launch with BUSY and returns word ^ 8'h99.
  initial begin
    logic [7:0] exp_w;
    int len;
    forever begin
      @(negedge clk);
      if (rst && !no_busy && !spi_enable) begin
        if (tx_exp.size() == 0) begin
          check("spi_unexpected_launch", {24'h0, spi_tx_data}, 32'hFFFF_FFFF);
        end else begin
          exp_w = tx_exp.pop_front();
          check("spi_tx_data", {24'h0, spi_tx_data}, {24'h0, exp_w});
        end
        check("spi_addr_at_launch", {31'h0, spi_addr}, 32'h0);
        len = rand_busy ? int'($urandom_range(1, 5)) : busy_len;
        repeat (2) @(negedge clk);
        spi_rx_data = spi_tx_data ^ RSP_XOR;
        spi_busy    = 1'b1;
        repeat (len) @(negedge clk);
        spi_busy = 1'b0;
        bf_cyc   = cyc;
        bf_count++;
        @(negedge clk);  // CAPTURE cycle; select may legitimately stay low
      end
    end
  end

  // Host reader
  initial begin
    forever begin
      @(posedge clk); #1;
      rd_en = 1'b0;
      if (rd_mode == 1) rd_en = !rx_empty;
      else if (rd_mode == 2) rd_en = !rx_empty && ($urandom_range(0, 1) == 1);
      else if (rd_one && !rx_empty) begin
        rd_en  = 1'b1;
        rd_one = 1'b0;
      end
    end
  end

  // RX monitor: every accepted host read is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst && rd_en && !rx_empty) begin
      if (rx_exp.size() == 0) begin
        check("rx_unexpected", {24'h0, rd_data}, 32'hFFFF_FFFF);
      end else begin
        check("rx_data", {24'h0, rd_data}, {24'h0, rx_exp.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int base, glitch, lcyc, n;
    logic [7:0] d;

    // ---------------- reset values ----------------
    tick(); tick();
    check("rst_tx_full",  {31'h0, tx_full},     32'h0);
    check("rst_rx_empty", {31'h0, rx_empty},    32'h1);
    check("rst_rd_data",  {24'h0, rd_data},     32'h0);
    check("rst_enable",   {31'h0, spi_enable},  32'h1);
    check("rst_addr",     {31'h0, spi_addr},    32'h1);
    check("rst_tx_data",  {24'h0, spi_tx_data}, 32'h0);
    check("rst_err",      {31'h0, err},         32'h0);
    rst = 1'b1;
    tick();

    // ---------------- single word, latency ----------------
    busy_len = 10;
    @(posedge clk); #1;          // cycle 0
    wr(8'hA5, 1'b1);             // returns in cycle 1
    tick();
    check("lat_enable_c1", {31'h0, spi_enable}, 32'h1);
    tick();                      // cycle 2
    check("lat_enable_c2",  {31'h0, spi_enable},  32'h0);
    check("lat_tx_data_c2", {24'h0, spi_tx_data}, 32'hA5);
    n = 0;
    while (rx_empty && n < 60) begin tick(); n++; end
    if (n >= 60) expire("single_rx_wait");
    check("single_rd_data",  {24'h0, rd_data},  32'h3C);
    check("single_rx_empty", {31'h0, rx_empty}, 32'h0);
    check("capture_latency", cyc - bf_cyc, 32'd2);
    rd_one = 1'b1;
    wait_drain(20, "single_drain");

    // ---------------- three-word burst ----------------
    busy_len = 4;
    base = bf_count;
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    wr(8'h03, 1'b1);
    n = 0;
    while (spi_addr && n < 10) begin tick(); n++; end
    if (n >= 10) expire("burst_start");
    glitch = 0;
    n = 0;
    while (bf_count < base + 3 && n < 200) begin
      tick(); n++;
      if (spi_addr) glitch++;
    end
    if (n >= 200) expire("burst_wait");
    tick();                      // CAPTURE of the third word
    if (spi_addr) glitch++;
    tick();                      // back in IDLE
    check("burst_addr_glitches", glitch, 32'd0);
    check("burst_addr_end",   {31'h0, spi_addr},   32'h1);
    check("burst_enable_end", {31'h0, spi_enable}, 32'h1);
    rd_mode = 1;
    wait_drain(40, "burst_drain");
    rd_mode = 0;

    // ---------------- RX backpressure ----------------
    base = bf_count;
    wr(8'h10, 1'b1);
    wr(8'h20, 1'b1);
    wr(8'h30, 1'b1);
    wr(8'h40, 1'b1);
    wr(8'h50, 1'b1);
    tick();
    check("bp_tx_full", {31'h0, tx_full}, 32'h1);
    wait_bf(base + 4, 300, "bp_four_done");
    repeat (20) tick();
    check("bp_held_xfers", bf_count - base, 32'd4);
    check("bp_enable_idle", {31'h0, spi_enable}, 32'h1);
    check("bp_addr_idle",   {31'h0, spi_addr},   32'h1);
    check("bp_tx_not_full", {31'h0, tx_full},    32'h0);
    check("bp_rx_head",     {24'h0, rd_data},    32'h89);
    rd_one = 1'b1;
    wait_bf(base + 5, 100, "bp_fifth_done");
    rd_mode = 1;
    wait_drain(60, "bp_drain");
    rd_mode = 0;

    // ---------------- BUSY timeout ----------------
    no_busy = 1'b1;
    wr(8'hC3, 1'b0);
    n = 0;
    while (spi_enable && n < 10) begin tick(); n++; end
    if (n >= 10) expire("tmo_launch");
    lcyc = cyc;
    check("tmo_tx_data", {24'h0, spi_tx_data}, 32'hC3);
    n = 0;
    while (!err && n < 40) begin tick(); n++; end
    if (n >= 40) expire("tmo_err_wait");
    // one LAUNCH cycle plus BUSY_TMO unanswered WAIT_BUSY cycles
    check("tmo_err_delay", cyc - lcyc, BUSY_TMO + 1);
    check("tmo_enable",   {31'h0, spi_enable}, 32'h1);
    check("tmo_addr",     {31'h0, spi_addr},   32'h1);
    check("tmo_rx_empty", {31'h0, rx_empty},   32'h1);
    no_busy = 1'b0;
    wr(8'h5A, 1'b1);
    rd_mode = 1;
    wait_drain(80, "tmo_next_word");
    rd_mode = 0;
    check("tmo_err_sticky", {31'h0, err}, 32'h1);

    // ---------------- reset during WAIT_DONE ----------------
    busy_len = 10;
    for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i), 1'b1);
    n = 0;
    while (!spi_busy && n < 20) begin tick(); n++; end
    if (n >= 20) expire("rst_busy_wait");
    repeat (3) tick();
    check("mid_tx_full", {31'h0, tx_full}, 32'h1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;                          // no clock edge since reset fell
    check("mid_rst_enable",   {31'h0, spi_enable}, 32'h1);
    check("mid_rst_addr",     {31'h0, spi_addr},   32'h1);
    check("mid_rst_tx_full",  {31'h0, tx_full},    32'h0);
    check("mid_rst_rx_empty", {31'h0, rx_empty},   32'h1);
    check("mid_rst_err",      {31'h0, err},        32'h0);
    repeat (20) tick();
    tx_exp.delete();
    rx_exp.delete();
    rst = 1'b1;
    tick();

    // ---------------- random bytes, random reads ----------------
    rand_busy = 1'b1;
    rd_mode   = 2;
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom_range(0, 255));
      wr(d, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    wait_drain(4000, "rand_drain");
    check("rand_tx_left", tx_exp.size(), 32'd0);
    check("rand_err",     {31'h0, err},  32'h0);
    rd_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
